// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and result register around a combinational 8-bit ALU.
// Optional feature macro: ALU_SEQ_DIVZERO_EN (divide-by-zero saturation and flag).
`timescale 1ns/1ps

module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_A,
    input  logic [7:0]                 cmd_B,
    input  logic [3:0]                 cmd_sel,
    output logic [7:0]                 ALU_A,
    output logic [7:0]                 ALU_B,
    output logic [3:0]                 ALU_sel,
    input  logic [7:0]                 ALU_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_data,
    output logic [3:0]                 res_sel,
    output logic                       div_zero,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          capture;
    logic          res_take;

    assign cmd_ready = (level != LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign res_take  = res_valid && res_ready;

    // Storage is left unreset so it maps onto RAM; level alone marks entries live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_A, cmd_B, cmd_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (level != '0) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WAIT;
            ST_WAIT: begin
                // A push landing in the same cycle counts toward "non-empty".
                if (res_ready) begin
                    state_next = ((level != '0) || push) ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        case (state)
            ST_LOAD: pop     = 1'b1;
            ST_EXEC: capture = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_sel <= '0;
        end else if (pop) begin
            {ALU_A, ALU_B, ALU_sel} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
        end else if (state == ST_WAIT && res_take) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_DIVZERO_EN
    logic div_zero_reg;
    logic divz_hit;

    assign divz_hit = (ALU_sel == 4'b0011) && (ALU_B == 8'h00);
    assign div_zero = div_zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data     <= '0;
            res_sel      <= '0;
            div_zero_reg <= 1'b0;
        end else if (capture) begin
            res_data     <= divz_hit ? 8'hFF : ALU_result;
            res_sel      <= ALU_sel;
            div_zero_reg <= divz_hit;
        end
    end
`else
    assign div_zero = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_sel  <= '0;
        end else if (capture) begin
            res_data <= ALU_result;
            res_sel  <= ALU_sel;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU model in the loop.
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_A;
    logic [7:0] cmd_B;
    logic [3:0] cmd_sel;
    logic [7:0] ALU_A;
    logic [7:0] ALU_B;
    logic [3:0] ALU_sel;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_sel;
    logic       div_zero;
    logic [2:0] level;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_A      (cmd_A),
        .cmd_B      (cmd_B),
        .cmd_sel    (cmd_sel),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_sel    (ALU_sel),
        .ALU_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_sel    (res_sel),
        .div_zero   (div_zero),
        .level      (level)
    );

    // Stand-in for alu_8bit; divide by zero yields 0 from the raw ALU.
    always_comb begin
        alu_result = 8'h00;
        case (ALU_sel)
            4'd0: alu_result = ALU_A + ALU_B;
            4'd1: alu_result = ALU_A - ALU_B;
            4'd2: alu_result = ALU_A * ALU_B;
            4'd3: alu_result = (ALU_B == 8'h00) ? 8'h00 : ALU_A / ALU_B;
            4'd4: alu_result = ALU_A & ALU_B;
            4'd5: alu_result = ALU_A | ALU_B;
            4'd6: alu_result = ALU_A ^ ALU_B;
            default: alu_result = 8'h00;
        endcase
    end

`ifdef ALU_SEQ_DIVZERO_EN
    localparam logic [7:0] DZ_DATA = 8'hFF;
    localparam logic       DZ_FLAG = 1'b1;
`else
    localparam logic [7:0] DZ_DATA = 8'h00;
    localparam logic       DZ_FLAG = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] sel;
        logic       dz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    localparam logic [7:0] VA [10] = '{8'h11, 8'hF0, 8'h0A, 8'h00, 8'h03, 8'h20, 8'hFF, 8'h81, 8'h0F, 8'h0F};
    localparam logic [7:0] VB [10] = '{8'h22, 8'h20, 8'h05, 8'h01, 8'h05, 8'h08, 8'h10, 8'h00, 8'hF0, 8'hF0};
    localparam logic [3:0] VS [10] = '{4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd2,  4'd3,  4'd3,  4'd4,  4'd5};
    localparam logic [7:0] VR [10] = '{8'h33, 8'h10, 8'h05, 8'hFF, 8'h0F, 8'h00, 8'h0F, DZ_DATA, 8'h00, 8'hFF};
    localparam logic       VZ [10] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  DZ_FLAG, 1'b0,  1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                        input logic [7:0] ed, input logic edz);
        int   n;
        exp_t e;
        n = 0;
        cmd_valid = 1'b1;
        cmd_A = a;
        cmd_B = b;
        cmd_sel = s;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("push_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.data = ed;
        e.sel  = s;
        e.dz   = edz;
        exp_q.push_back(e);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_res_sel"},   res_sel,   0);
        check({tag, "_div_zero"},  div_zero,  0);
        check({tag, "_alu_a"},     ALU_A,     0);
        check({tag, "_alu_b"},     ALU_B,     0);
        check({tag, "_alu_sel"},   ALU_sel,   0);
        check({tag, "_level"},     level,     0);
    endtask

    // Monitor: scoreboard compare on each handshake plus hold-stability checks.
    logic        hold_prev = 1'b0;
    logic [12:0] fields_prev = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", res_valid, 1);
                check("hold_fields", {res_data, res_sel, div_zero}, fields_prev);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_sel", res_sel, e.sel);
                    check("div_zero", div_zero, e.dz);
                end
            end
            hold_prev   = res_valid && !res_ready;
            fields_prev = {res_data, res_sel, div_zero};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        cmd_A = '0;
        cmd_B = '0;
        cmd_sel = '0;
        res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op and latency
        push(8'h12, 8'h34, 4'd0, 8'h46, 1'b0);
        check("lat_level_after_push", level, 1);
        check("lat_t0_valid", res_valid, 0);
        @(posedge clk); #1;
        check("lat_t1_valid", res_valid, 0);
        @(posedge clk); #1;
        check("lat_t2_valid", res_valid, 0);
        check("lat_alu_a", ALU_A, 8'h12);
        check("lat_alu_b", ALU_B, 8'h34);
        check("lat_level_popped", level, 0);
        @(posedge clk); #1;
        check("lat_t3_valid", res_valid, 1);
        @(posedge clk); #1;
        check("single_valid_cleared", res_valid, 0);
        check("single_level", level, 0);

        // Truncation and divide by zero
        push(8'h10, 8'h10, 4'd2, 8'h00, 1'b0);
        push(8'h01, 8'h02, 4'd1, 8'hFF, 1'b0);
        push(8'h20, 8'h00, 4'd3, DZ_DATA, DZ_FLAG);
        push(8'h20, 8'h04, 4'd3, 8'h08, 1'b0);
        drain();

        // Backpressure until full, then release
        res_ready = 1'b0;
        push(8'h01, 8'h01, 4'd0, 8'h02, 1'b0);
        push(8'h10, 8'h20, 4'd0, 8'h30, 1'b0);
        push(8'h05, 8'h03, 4'd1, 8'h02, 1'b0);
        push(8'h07, 8'h06, 4'd2, 8'h2A, 1'b0);
        push(8'hFF, 8'h01, 4'd0, 8'h00, 1'b0);
        cmd_valid = 1'b1;
        cmd_A = 8'h64;
        cmd_B = 8'h05;
        cmd_sel = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_level", level, 4);
        @(posedge clk); #1;
        res_ready = 1'b1;
        push(8'h64, 8'h05, 4'd3, 8'h14, 1'b0);
        drain();

        // Simultaneous push and pop during LOAD at level 2, then a wrapping stream
        res_ready = 1'b0;
        push(8'h03, 8'h04, 4'd0, 8'h07, 1'b0);
        push(8'h09, 8'h02, 4'd1, 8'h07, 1'b0);
        push(8'h06, 8'h07, 4'd0, 8'h0D, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pp_level_before", level, 2);
        res_ready = 1'b1;
        @(posedge clk); #1;
        push(8'h0C, 8'h03, 4'd2, 8'h24, 1'b0);
        check("pp_level_same", level, 2);
        for (int i = 0; i < 10; i++) begin
            push(VA[i], VB[i], VS[i], VR[i], VZ[i]);
        end
        drain();

        // Reset during EXEC with three commands pending
        res_ready = 1'b0;
        push(8'h01, 8'h02, 4'd0, 8'h03, 1'b0);
        push(8'h02, 8'h02, 4'd0, 8'h04, 1'b0);
        push(8'h03, 8'h02, 4'd0, 8'h05, 1'b0);
        push(8'h04, 8'h02, 4'd0, 8'h06, 1'b0);
        push(8'h05, 8'h02, 4'd0, 8'h07, 1'b0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_level", level, 3);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_valid", res_valid, 0);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_level", level, 0);
        push(8'h08, 8'h09, 4'd0, 8'h11, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
